// File: rtl/mpu_matrix_loader.sv
// Serial byte loader that assembles an N x N matrix plus a scalar factor for the scalar-multiply stage.
// Optional synchronous abort input is compiled in with `define MPU_LOADER_ABORT_EN.
//
// state       | meaning
// LOAD_MATRIX | accepting matrix elements, elem_count = index of next element
// LOAD_FACTOR | all N*N elements held, accepting the scalar factor
// ISSUE       | operand set presented on out_*, waiting for out_ready
module mpu_matrix_loader #(
    parameter int N = 5
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MPU_LOADER_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic [8*N*N-1:0]   out_matrix,
    output logic [7:0]         out_factor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         elem_count
);

    localparam int NE = N * N;
    localparam logic [4:0] LAST_IDX = 5'(NE - 1);

    typedef enum logic [1:0] {
        LOAD_MATRIX,
        LOAD_FACTOR,
        ISSUE
    } state_t;

    state_t            state_q;
    logic [4:0]        count_q;
    logic [8*NE-1:0]   matrix_q;
    logic [7:0]        factor_q;
    logic              valid_q;
    logic              accept;
    logic              abort_w;

`ifdef MPU_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Gated by rst_n so the upstream sees no ready while the block is held in reset.
    assign in_ready = rst_n && (state_q != ISSUE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_MATRIX;
            count_q  <= '0;
            matrix_q <= '0;
            factor_q <= '0;
            valid_q  <= 1'b0;
        end else if (abort_w) begin
            state_q  <= LOAD_MATRIX;
            count_q  <= '0;
            matrix_q <= '0;
            factor_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD_MATRIX: begin
                    if (accept) begin
                        for (int k = 0; k < NE; k++) begin
                            if (count_q == 5'(k)) matrix_q[8*k +: 8] <= in_data;
                        end
                        count_q <= count_q + 5'd1;
                        if (count_q == LAST_IDX) state_q <= LOAD_FACTOR;
                    end
                end
                LOAD_FACTOR: begin
                    if (accept) begin
                        factor_q <= in_data;
                        valid_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Matrix and factor are left in place; only the next load overwrites them.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        count_q <= '0;
                        state_q <= LOAD_MATRIX;
                    end
                end
                default: state_q <= LOAD_MATRIX;
            endcase
        end
    end

    assign out_matrix = matrix_q;
    assign out_factor = factor_q;
    assign out_valid  = valid_q;
    assign elem_count = count_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: directed table, corner sequences and a queue-based random model.
// Abort scenario is compiled in with `define MPU_LOADER_ABORT_EN.
module tb_mpu_matrix_loader;

    localparam int N  = 5;
    localparam int NE = N * N;
    localparam int W  = 8 * NE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [W-1:0]  out_matrix;
    logic [7:0]    out_factor;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    elem_count;
`ifdef MPU_LOADER_ABORT_EN
    logic          abort = 1'b0;
`endif

    mpu_matrix_loader #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MPU_LOADER_ABORT_EN
        .abort      (abort),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_matrix (out_matrix),
        .out_factor (out_factor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .elem_count (elem_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every byte the block has taken for the current operand set, in order.
    // 25 bytes = matrix complete, 26 bytes = factor taken and the set is on offer.
    logic [7:0] q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [W-1:0] m;
        int sz;
        sz = q.size();
        chk("in_ready", W'(in_ready), W'(sz < NE + 1));
        chk("out_valid", W'(out_valid), W'(sz == NE + 1));
        chk("elem_count", W'(elem_count), W'((sz > NE) ? NE : sz));
        if (sz == NE + 1) begin
            m = '0;
            for (int k = 0; k < NE; k++) m[8*k +: 8] = q[k];
            chk("out_matrix", out_matrix, m);
            chk("out_factor", W'(out_factor), W'(q[NE]));
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic a);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
`ifdef MPU_LOADER_ABORT_EN
        abort     = a;
`endif
        @(posedge clk);
        #1;
        if (a) q.delete();
        else if (q.size() == NE + 1) begin
            if (r) q.delete();
        end else if (v) q.push_back(d);
        model_check();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
            n++;
        end
        chk({name, "_drain_timeout"}, W'(q.size()), W'(0));
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t tbl[NE + 2];

    initial begin
        int rise0, rise1, cnum;
        logic prev_v;

        for (int i = 0; i < NE; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b1, 1'b1, 1'b0, 5'(i + 1)};
        tbl[NE]     = '{1'b1, 8'd2,  1'b1, 1'b0, 1'b1, 5'd25};
        tbl[NE + 1] = '{1'b0, 8'd99, 1'b1, 1'b1, 1'b0, 5'd0};

        // Reset state, with in_valid high to show it has no effect on in_ready.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_elem_count", W'(elem_count), W'(0));
        chk("rst_out_matrix", out_matrix, '0);
        chk("rst_out_factor", W'(out_factor), W'(0));
        @(negedge clk); rst_n = 1'b1;

        // Bytes 1..25 then factor 2 with out_ready held high.
        for (int i = 0; i < NE + 2; i++) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_in_ready", i), W'(in_ready), W'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_elem_count", i), W'(elem_count), W'(tbl[i].e_cnt));
            if (tbl[i].e_vld) begin
                chk("tbl_elem0", W'(out_matrix[0 +: 8]), W'(1));
                chk("tbl_elem24", W'(out_matrix[192 +: 8]), W'(25));
                chk("tbl_factor", W'(out_factor), W'(2));
            end
        end

        // Downstream stalls for 10 cycles while upstream keeps offering a byte.
        for (int i = 0; i < NE + 1; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'hAA, 1'b0, 1'b0);
            chk("stall_out_valid", W'(out_valid), W'(1));
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_factor", W'(out_factor), W'(8'h59));
        end
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("release_elem_count", W'(elem_count), W'(0));
        chk("release_out_valid", W'(out_valid), W'(0));
        chk("release_matrix_kept", W'(out_matrix[0 +: 8]), W'(8'h40));
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("after_release_elem0", W'(out_matrix[0 +: 8]), W'(8'h55));
        drain("stall");

        // Asynchronous reset after 12 beats discards the partial load.
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_elem_count", W'(elem_count), W'(0));
        chk("midrst_out_matrix", out_matrix, '0);
        chk("midrst_in_ready", W'(in_ready), W'(0));
        q.delete();
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        chk("postrst_elem0", W'(out_matrix[0 +: 8]), W'(8'h11));
        drain("postrst");

        // Back-to-back sets: the second out_valid rise is 27 cycles after the first.
        rise0 = -1; rise1 = -1; prev_v = out_valid;
        for (cnum = 0; cnum < 60; cnum++) begin
            cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (out_valid && !prev_v) begin
                if (rise0 < 0) rise0 = cnum;
                else if (rise1 < 0) rise1 = cnum;
            end
            prev_v = out_valid;
        end
        chk("b2b_first_rise", W'(rise0), W'(NE));
        chk("b2b_spacing", W'(rise1 - rise0), W'(NE + 2));
        drain("b2b");

        // Random in_valid and out_ready against the queue model.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
        drain("rand");

`ifdef MPU_LOADER_ABORT_EN
        // Abort arriving with the factor beat wins over the handshake.
        for (int i = 0; i < NE; i++) cyc(1'b1, 8'(i + 7), 1'b1, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_elem_count", W'(elem_count), W'(0));
        chk("abort_out_factor", W'(out_factor), W'(0));
        chk("abort_out_matrix", out_matrix, '0);
        cyc(1'b1, 8'h31, 1'b1, 1'b0);
        chk("abort_next_elem0", W'(out_matrix[0 +: 8]), W'(8'h31));
        drain("abort");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

Interface
REQ-001 The block SHALL have one parameter: N, default 5, the matrix dimension (N x N elements of 8 bits); only N=5 is required to be verified.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream byte is valid.
REQ-005 The block SHALL have port in_data, input, 8 bits: the upstream byte, either a matrix element or the factor.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-007 The block SHALL have port out_matrix, output, 8*N*N bits: the assembled flat matrix that feeds the scalar-multiply stage.
REQ-008 The block SHALL have port out_factor, output, 8 bits: the assembled scalar factor.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_matrix and out_factor hold a complete operand set.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the operand set.
REQ-011 The block SHALL have port elem_count, output, 5 bits: the number of matrix elements accepted in the current load.

Function
REQ-012 The FSM SHALL have exactly three states: LOAD_MATRIX, LOAD_FACTOR and ISSUE.
REQ-013 A beat SHALL be accepted only on a rising edge where in_valid && in_ready.
REQ-014 in_ready SHALL be 1 in LOAD_MATRIX and LOAD_FACTOR, 0 in ISSUE, and 0 while rst_n is low; it SHALL be decoded from registered state with no combinational path from in_valid.
REQ-015 In LOAD_MATRIX, accepted beat k (k = elem_count, 0..N*N-1) SHALL be written to out_matrix[8*k +: 8], so that element (col,row) sits at bit offset 8*(row + N*col).
REQ-016 elem_count SHALL increment by 1 per accepted matrix beat; the beat with elem_count = N*N-1 SHALL move the FSM to LOAD_FACTOR, and elem_count SHALL then hold N*N.
REQ-017 In LOAD_FACTOR, an accepted beat SHALL be written to out_factor and SHALL move the FSM to ISSUE; out_valid SHALL rise on that same edge, i.e. one cycle after the factor beat is presented.
REQ-018 In ISSUE, out_matrix and out_factor SHALL remain stable and out_valid SHALL remain 1 until out_valid && out_ready at a rising edge.
REQ-019 On the ISSUE handshake edge, the FSM SHALL move to LOAD_MATRIX, elem_count SHALL become 0 and out_valid SHALL become 0; out_matrix and out_factor SHALL retain their values until overwritten.
REQ-020 out_matrix and out_factor are defined only while out_valid = 1; partially overwritten contents during a load are permitted.
REQ-021 Back-to-back throughput SHALL be one operand set per N*N+2 cycles (26 beats + 1 issue cycle) when in_valid and out_ready are held at 1.
REQ-022 in_valid asserted in ISSUE SHALL be ignored; upstream holds the byte until in_ready rises.
REQ-023 The block SHALL perform no arithmetic; bytes SHALL be stored unmodified as 8-bit unsigned values.

Reset
REQ-024 While rst_n = 0 the block SHALL immediately force: state LOAD_MATRIX, elem_count 0, out_matrix all 0, out_factor 0, out_valid 0, in_ready 0.
REQ-025 Reset asserted mid-load or in ISSUE SHALL discard all partial data; after release the next accepted beat SHALL be element 0.

Configuration
REQ-026 With macro MPU_LOADER_ABORT_EN defined, the block SHALL add a 1-bit input abort; abort = 1 at a rising edge SHALL force state LOAD_MATRIX, elem_count 0, out_valid 0 and out_matrix/out_factor 0, discarding any beat accepted on the same edge; abort SHALL take priority over both handshakes.
REQ-027 Without MPU_LOADER_ABORT_EN, the abort port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: stream bytes 1..25 then factor 2, out_ready=1 -> out_valid high for exactly one cycle, out_matrix[0 +: 8]=1, out_matrix[192 +: 8]=25, out_factor=2.
REQ-029 The bench SHALL cover: same stream with out_ready=0 for 10 cycles -> out_valid held 10+ cycles, in_ready=0 throughout, outputs stable; release -> elem_count=0 next cycle.
REQ-030 The bench SHALL cover: in_valid toggling 1/0 randomly during load -> elem_count counts only accepted beats, and the final matrix equals the accepted sequence in order.
REQ-031 The bench SHALL cover: rst_n pulsed low after 12 beats -> out_valid=0, elem_count=0 and out_matrix=0 at once; a fresh 26-beat stream then produces a correct set.
REQ-032 The bench SHALL cover: two back-to-back sets with in_valid=1 and out_ready=1 -> the second out_valid rises exactly 27 cycles after the first.
REQ-033 With MPU_LOADER_ABORT_EN defined, the bench SHALL cover: abort=1 together with the factor beat -> no out_valid, elem_count=0, out_factor=0.
